// File: rtl/vivo_pop_packer.sv
// Packs variable-size VIVO FIFO pops into fixed WORD_ELEMS-element words; flush_i drains a partial word.
// Optional statistics counters are enabled by defining VIVO_POP_PACKER_STATS_EN.
module vivo_pop_packer #(
    parameter int unsigned ELEM_WIDTH    = 8,
    parameter int unsigned OUT_ELEMS_MAX = 4,
    parameter int unsigned WORD_ELEMS    = 8,
    localparam int unsigned NW = $clog2(OUT_ELEMS_MAX + 1),
    localparam int unsigned CW = $clog2(WORD_ELEMS + 1)
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             f_out_valid,
    output logic                             f_out_ready,
    input  logic [OUT_ELEMS_MAX*ELEM_WIDTH-1:0] f_out_data,
    input  logic [NW-1:0]                    f_out_num_elems,
    output logic [NW-1:0]                    f_out_req_elems,
    input  logic                             flush_i,
    output logic                             w_valid,
    input  logic                             w_ready,
    output logic [WORD_ELEMS*ELEM_WIDTH-1:0] w_data,
    output logic [CW-1:0]                    w_num_elems,
    output logic                             w_last
`ifdef VIVO_POP_PACKER_STATS_EN
    ,
    output logic [31:0]                      stat_words,
    output logic [31:0]                      stat_flushes,
    output logic [31:0]                      stat_starve
`endif
);

    if (WORD_ELEMS < OUT_ELEMS_MAX) begin : g_bad_cfg
        $error("vivo_pop_packer: WORD_ELEMS must be >= OUT_ELEMS_MAX");
    end

    typedef enum logic [0:0] {StFill, StDrain} state_e;

    state_e                                      r_state, w_state_d;
    logic [WORD_ELEMS-1:0][ELEM_WIDTH-1:0]       r_acc, w_acc_d;
    logic [CW-1:0]                               r_acc_cnt, w_acc_cnt_d;
    logic                                        r_flush_pend, w_flush_pend_d;
    logic [NW-1:0]                               r_req, w_req_d;
    logic                                        r_req_was_zero;
    logic                                        r_last, w_last_d;
    logic [OUT_ELEMS_MAX-1:0][ELEM_WIDTH-1:0]    w_pop_elems;
    logic                                        w_pop;
    logic [CW-1:0]                               w_space;

    assign w_pop_elems = f_out_data;
    assign f_out_ready = (r_state == StFill);
    assign w_pop       = f_out_valid && f_out_ready;

    always_comb begin
        w_state_d      = r_state;
        w_acc_d        = r_acc;
        w_acc_cnt_d    = r_acc_cnt;
        w_flush_pend_d = r_flush_pend;
        w_last_d       = r_last;
        w_req_d        = '0;
        w_space        = '0;

        unique case (r_state)
            StFill: begin
                if (w_pop) begin
                    for (int j = 0; j < int'(WORD_ELEMS); j++) begin
                        for (int i = 0; i < int'(OUT_ELEMS_MAX); i++) begin
                            if (i < int'(f_out_num_elems) && j == int'(r_acc_cnt) + i) begin
                                w_acc_d[j] = w_pop_elems[i];
                            end
                        end
                    end
                    w_acc_cnt_d = r_acc_cnt + CW'(f_out_num_elems);
                end
                if (flush_i) begin
                    w_flush_pend_d = 1'b1;
                end
                if (w_acc_cnt_d == CW'(WORD_ELEMS)) begin
                    w_state_d = StDrain;
                    w_last_d  = 1'b0;
                end else if (r_flush_pend && r_req_was_zero && !f_out_valid) begin
                    // One guard cycle after the request dropped lets an in-flight pop land first.
                    if (r_acc_cnt != '0) begin
                        w_state_d = StDrain;
                        w_last_d  = 1'b1;
                    end else begin
                        w_flush_pend_d = 1'b0;
                    end
                end
            end
            StDrain: begin
                if (flush_i) begin
                    w_flush_pend_d = 1'b1;
                end
                if (w_ready) begin
                    w_state_d   = StFill;
                    w_acc_d     = '0;
                    w_acc_cnt_d = '0;
                    w_last_d    = 1'b0;
                    // A flush seen while draining a full word survives into the next fill.
                    if (r_last) begin
                        w_flush_pend_d = 1'b0;
                    end
                end
            end
            default: w_state_d = StFill;
        endcase

        if (w_state_d == StFill && !w_flush_pend_d) begin
            w_space = CW'(WORD_ELEMS) - w_acc_cnt_d;
            w_req_d = (w_space > CW'(OUT_ELEMS_MAX)) ? NW'(OUT_ELEMS_MAX) : NW'(w_space);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state        <= StFill;
            r_acc          <= '0;
            r_acc_cnt      <= '0;
            r_flush_pend   <= 1'b0;
            r_req          <= '0;
            r_req_was_zero <= 1'b1;
            r_last         <= 1'b0;
        end else begin
            r_state        <= w_state_d;
            r_acc          <= w_acc_d;
            r_acc_cnt      <= w_acc_cnt_d;
            r_flush_pend   <= w_flush_pend_d;
            r_req          <= w_req_d;
            r_req_was_zero <= (r_req == '0);
            r_last         <= w_last_d;
        end
    end

    assign f_out_req_elems = r_req;
    assign w_valid         = (r_state == StDrain);
    assign w_data          = r_acc;
    assign w_num_elems     = r_acc_cnt;
    assign w_last          = r_last;

    a_pop_fits: assert property (@(posedge clk) disable iff (!rst_n)
        w_pop |-> (int'(f_out_num_elems) <= int'(WORD_ELEMS) - int'(r_acc_cnt)));

`ifdef VIVO_POP_PACKER_STATS_EN
    logic [31:0] r_stat_words, r_stat_flushes, r_stat_starve;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stat_words   <= '0;
            r_stat_flushes <= '0;
            r_stat_starve  <= '0;
        end else begin
            if (w_valid && w_ready && r_stat_words != '1) begin
                r_stat_words <= r_stat_words + 32'd1;
            end
            if (w_valid && w_ready && r_last && r_stat_flushes != '1) begin
                r_stat_flushes <= r_stat_flushes + 32'd1;
            end
            if (r_state == StFill && r_req != '0 && !f_out_valid && r_stat_starve != '1) begin
                r_stat_starve <= r_stat_starve + 32'd1;
            end
        end
    end

    assign stat_words   = r_stat_words;
    assign stat_flushes = r_stat_flushes;
    assign stat_starve  = r_stat_starve;
`endif

endmodule
